// File: rtl/fpu_mul_pkg.sv
// Shared fp16 types, FSM states and helpers for the multiply coprocessor.
// Holds the same flag/condition-code layout as the divide unit.
package fpu_mul_pkg;

   localparam int unsigned FRACW = 10;
   localparam int unsigned EXPW  = 5;
   localparam int          BIAS  = 15;
   localparam int unsigned SIGW  = FRACW + 1;
   localparam int unsigned PRODW = 2 * SIGW;

   typedef struct packed {
      logic             sign;
      logic [EXPW-1:0]  exp;
      logic [FRACW-1:0] frac;
   } fp16_t;

   typedef struct packed {
      logic z;
      logic c;
      logic n;
      logic v;
   } condCode_t;

   typedef struct packed {
      logic overflow;
      logic underflow;
      logic inexact;
      logic invalid;
   } opStatusFlag_t;

   typedef enum logic [1:0] {
      FPMUL_WAIT,
      FPMUL_SIGMUL,
      FPMUL_NORM,
      FPMUL_DONE
   } fpuMulState_t;

   localparam fp16_t QNAN = 16'h7E00;

   // Leading-zero count from the product MSB; returns PRODW for an all-zero word.
   function automatic logic [4:0] lzc(input logic [PRODW-1:0] x);
      logic [4:0] n;
      n = 5'(PRODW);
      for (int i = 0; i < int'(PRODW); i++) begin
         if (x[i]) n = 5'(int'(PRODW) - 1 - i);
      end
      return n;
   endfunction

   function automatic logic [EXPW-1:0] effExp(input fp16_t x);
      return (x.exp == '0) ? EXPW'(1) : x.exp;
   endfunction

   function automatic logic [SIGW-1:0] sigOf(input fp16_t x);
      return {x.exp != '0, x.frac};
   endfunction

endpackage

// File: rtl/fpu_mul_if.sv
// Coprocessor bus for fpu_mul: start/done handshake, operands, result and status.
interface fpu_mul_if;
   import fpu_mul_pkg::*;

   logic          start;
   fp16_t         fpuIn1;
   fp16_t         fpuIn2;
   fp16_t         fpuOut;
   logic          done;
   condCode_t     condCodes;
   opStatusFlag_t opStatusFlags;

   modport master (
      output start, fpuIn1, fpuIn2,
      input  fpuOut, done, condCodes, opStatusFlags
   );

   modport slave (
      input  start, fpuIn1, fpuIn2,
      output fpuOut, done, condCodes, opStatusFlags
   );

endinterface

// File: rtl/fpu_multiplier.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per step.
// Companion of the divider unit: start loads operands, step advances one iteration.
module fpu_multiplier #(
   parameter int unsigned WIDTH = 11
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               step,
   input  logic [WIDTH-1:0]   mcandIn,
   input  logic [WIDTH-1:0]   mplierIn,
   output logic [2*WIDTH-1:0] product,
   output logic               done
);
   localparam int unsigned CNTW = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   mplier;
   logic [CNTW-1:0]    cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
      end else if (start) begin
         mcand  <= {{WIDTH{1'b0}}, mcandIn};
         mplier <= mplierIn;
         acc    <= '0;
         cnt    <= '0;
      end else if (step) begin
         if (mplier[0]) acc <= acc + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
      end
   end

   assign product = acc;
   // High during the final iteration so the caller advances on that same edge.
   assign done    = step && (cnt == CNTW'(WIDTH - 1));

endmodule

// File: rtl/fpu_mul.sv
// fp16 multiply coprocessor: shift-add significand product, then normalize,
// round to nearest-even and register the result with condition codes and flags.
module fpu_mul
   import fpu_mul_pkg::*;
(
   input logic      clock,
   input logic      reset,
   fpu_mul_if.slave bus
);
   localparam int EW = EXPW + 2;

   fpuMulState_t  state, nextState;
   fp16_t         opA, opB, fpuOutReg, result;
   condCode_t     condReg, condNext;
   opStatusFlag_t flagReg, flagNext;
   logic          mulStart, mulStep, mulDone, loadResult;
   logic [SIGW-1:0]      sigIn1, sigIn2, mant;
   logic [SIGW:0]        sum;
   logic [PRODW-1:0]     prod, mNorm, mFinal;
   logic [2*PRODW-1:0]   dnWide;
   logic [4:0]           lz;
   logic signed [EW-1:0] expSum, expNorm, expEff, expRes, lzShift, room, lzExtra, dnAmt;
   logic guard, sticky, roundUp, resSign, aInf, bInf, aZero, bZero;

   assign sigIn1 = sigOf(bus.fpuIn1);
   assign sigIn2 = sigOf(bus.fpuIn2);

   fpu_multiplier #(.WIDTH(SIGW)) u_mult (
      .clock    (clock),
      .reset    (reset),
      .start    (mulStart),
      .step     (mulStep),
      .mcandIn  (sigIn1),
      .mplierIn (sigIn2),
      .product  (prod),
      .done     (mulDone)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= FPMUL_WAIT;
      else       state <= nextState;
   end

   always_comb begin
      nextState  = state;
      mulStart   = 1'b0;
      mulStep    = 1'b0;
      loadResult = 1'b0;
      unique case (state)
         FPMUL_WAIT: begin
            if (bus.start) begin
               mulStart  = 1'b1;
               nextState = FPMUL_SIGMUL;
            end
         end
         FPMUL_SIGMUL: begin
            mulStep = 1'b1;
            if (mulDone) nextState = FPMUL_NORM;
         end
         FPMUL_NORM: begin
            loadResult = 1'b1;
            nextState  = FPMUL_DONE;
         end
         FPMUL_DONE: begin
            if (!bus.start) nextState = FPMUL_WAIT;
         end
         default: nextState = FPMUL_WAIT;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         opA       <= '0;
         opB       <= '0;
         fpuOutReg <= '0;
         condReg   <= '0;
         flagReg   <= '0;
      end else begin
         if (mulStart) begin
            opA <= bus.fpuIn1;
            opB <= bus.fpuIn2;
         end
         if (loadResult) begin
            fpuOutReg <= result;
            condReg   <= condNext;
            flagReg   <= flagNext;
         end
      end
   end

   always_comb begin
      resSign = opA.sign ^ opB.sign;
      aInf    = (opA.exp == '1);
      bInf    = (opB.exp == '1);
      aZero   = (opA.exp == '0) && (opA.frac == '0);
      bZero   = (opB.exp == '0) && (opB.frac == '0);
      expSum  = $signed({2'b00, effExp(opA)}) + $signed({2'b00, effExp(opB)}) - EW'(BIAS);

      // Denormal operands: pull the leading one up, but never below exponent 1.
      lz      = lzc(prod);
      room    = expSum - EW'(1);
      lzExtra = $signed({2'b00, lz}) - EW'(1);
      lzShift = '0;
      if (!prod[PRODW-1] && !prod[PRODW-2] && (room > EW'(0))) begin
         lzShift = (lzExtra < room) ? lzExtra : room;
      end
      if (prod[PRODW-1]) begin
         mNorm   = prod;
         expNorm = expSum + EW'(1);
      end else begin
         mNorm   = prod << (lzShift + EW'(1));
         expNorm = expSum - lzShift;
      end

      if (expNorm < EW'(1)) begin
         dnAmt  = EW'(1) - expNorm;
         expEff = EW'(1);
      end else begin
         dnAmt  = '0;
         expEff = expNorm;
      end
      dnWide  = {mNorm, {PRODW{1'b0}}} >> dnAmt;
      mFinal  = dnWide[2*PRODW-1 -: PRODW];

      mant    = mFinal[PRODW-1 -: SIGW];
      guard   = mFinal[PRODW-SIGW-1];
      sticky  = (|mFinal[PRODW-SIGW-2:0]) | (|dnWide[PRODW-1:0]);
      roundUp = guard & (sticky | mant[0]);
      sum     = {1'b0, mant} + {{SIGW{1'b0}}, roundUp};

      // A missing hidden bit after rounding means a denormal encoding.
      if (sum[SIGW])       expRes = expEff + EW'(1);
      else if (sum[FRACW]) expRes = expEff;
      else                 expRes = '0;

      result           = {resSign, EXPW'(expRes), sum[FRACW-1:0]};
      flagNext         = '0;
      flagNext.inexact = guard | sticky;
      if (expRes >= EW'((1 << EXPW) - 1)) begin
         result            = {resSign, {EXPW{1'b1}}, {FRACW{1'b0}}};
         flagNext.overflow = 1'b1;
         flagNext.inexact  = 1'b1;
      end else begin
         flagNext.underflow = (expRes == '0) && (guard | sticky);
      end

      if (aInf || bInf) begin
         flagNext = '0;
         if (aZero || bZero) begin
            result           = QNAN;
            flagNext.invalid = 1'b1;
         end else begin
            result = {resSign, {EXPW{1'b1}}, {FRACW{1'b0}}};
         end
      end else if (aZero || bZero) begin
         result   = {resSign, {EXPW{1'b0}}, {FRACW{1'b0}}};
         flagNext = '0;
      end

      condNext   = '0;
      condNext.z = (result.exp == '0) && (result.frac == '0);
      condNext.n = result.sign;
   end

   assign bus.fpuOut        = fpuOutReg;
   assign bus.done          = (state == FPMUL_DONE);
   assign bus.condCodes     = condReg;
   assign bus.opStatusFlags = flagReg;

endmodule

// File: tb/tb_fpu_mul.sv
// Scoreboard bench for fpu_mul: directed and random fp16 products against a
// value-level rounding model; a separate monitor checks each completed result.
module tb_fpu_mul;
   import fpu_mul_pkg::*;

   logic clock;
   logic reset;
   int   nVec = 0;
   int   nMis = 0;

   fpu_mul_if bus ();

   fpu_mul dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // {a, b, expected{fpuOut, condCodes, opStatusFlags}}
   logic [55:0] expQ [$];

   localparam int NDIR = 12;
   logic [55:0] dirVec [NDIR] = '{
      {16'h3E00, 16'h4000, 24'h420000},
      {16'h3C01, 16'h3C01, 24'h3C0202},
      {16'h3C00, 16'h3C00, 24'h3C0000},
      {16'h7BFF, 16'h4000, 24'h7C000A},
      {16'hFBFF, 16'h4000, 24'hFC002A},
      {16'h0400, 16'h3800, 24'h020000},
      {16'h0001, 16'h3400, 24'h000086},
      {16'h8000, 16'h4500, 24'h8000A0},
      {16'h7C00, 16'h0000, 24'h7E0001},
      {16'h7C00, 16'hC000, 24'hFC0020},
      {16'h0001, 16'h0001, 24'h000086},
      {16'h3C00, 16'h3C00, 24'h3C0000}
   };

   // Exact value p*2^e rounded onto the fp16 grid, nearest-even.
   function automatic logic [23:0] refMul(input logic [15:0] a, input logic [15:0] b);
      logic        s, inx, ovf, unf, inv;
      logic [15:0] r;
      longint      mA, mB, p, m, rem, half;
      int          e, msb, q, k, expF, fracF;
      bit          aInf, bInf, aZero, bZero;
      s     = a[15] ^ b[15];
      aInf  = (a[14:10] == 5'h1F);
      bInf  = (b[14:10] == 5'h1F);
      aZero = (a[14:0] == 15'h0);
      bZero = (b[14:0] == 15'h0);
      inx = 1'b0; ovf = 1'b0; unf = 1'b0; inv = 1'b0;
      if ((aInf || bInf) && (aZero || bZero)) begin
         r = 16'h7E00; inv = 1'b1;
      end else if (aInf || bInf) begin
         r = {s, 5'h1F, 10'h0};
      end else if (aZero || bZero) begin
         r = {s, 15'h0};
      end else begin
         mA = (a[14:10] != 0) ? 64'(1024 + int'(a[9:0])) : 64'(a[9:0]);
         mB = (b[14:10] != 0) ? 64'(1024 + int'(b[9:0])) : 64'(b[9:0]);
         p  = mA * mB;
         e  = ((a[14:10] != 0) ? int'(a[14:10]) : 1) + ((b[14:10] != 0) ? int'(b[14:10]) : 1) - 50;
         msb = 0;
         for (int i = 0; i < 30; i++) if (p[i]) msb = i;
         q = msb + e;
         if (q < -14) q = -14;
         q = q - 10;
         k = q - e;
         if (k > 0) begin
            m    = p >> k;
            rem  = p - (m << k);
            half = 64'sd1 << (k - 1);
            if (rem > half || (rem == half && m[0])) m = m + 1;
            inx = (rem != 0);
         end else begin
            m = p << (-k);
         end
         if (m == 2048) begin m = 1024; q = q + 1; end
         if (m >= 1024) begin expF = q + 25; fracF = int'(m) - 1024; end
         else           begin expF = 0;      fracF = int'(m);        end
         if (expF >= 31) begin
            r = {s, 5'h1F, 10'h0}; ovf = 1'b1; inx = 1'b1;
         end else begin
            r = {s, 5'(expF), 10'(fracF)};
         end
         unf = (expF == 0) && inx;
      end
      return {r, (r[14:0] == 15'h0), 1'b0, r[15], 1'b0, ovf, unf, inx, inv};
   endfunction

   function automatic logic [15:0] randOperand();
      logic [4:0] e;
      logic [9:0] f;
      f = 10'($urandom);
      case ($urandom_range(0, 9))
         0:       e = 5'h00;
         1:       e = 5'h1F;
         2:       e = 5'($urandom_range(1, 3));
         3:       e = 5'($urandom_range(27, 30));
         4:       begin e = 5'h00; f = 10'h0; end
         default: e = 5'($urandom_range(1, 30));
      endcase
      return {1'($urandom), e, f};
   endfunction

   task automatic runOp(input logic [15:0] a, input logic [15:0] b, input logic [23:0] expd,
                        input bit hold);
      int lat;
      @(negedge clock);
      bus.start  = 1'b1;
      bus.fpuIn1 = a;
      bus.fpuIn2 = b;
      expQ.push_back({a, b, expd});
      @(posedge clock);
      #1;
      if (!hold) begin
         bus.start  = 1'b0;
         bus.fpuIn1 = 16'($urandom);
         bus.fpuIn2 = 16'($urandom);
      end
      lat = 0;
      while (!bus.done && lat < 40) begin
         @(posedge clock);
         #1;
         lat++;
      end
      nVec++;
      if (lat != 12) begin
         nMis++;
         $display("FAIL latency a=%h b=%h: got %0d cycles, want 12", a, b, lat);
      end
      if (hold) begin
         for (int i = 0; i < 14; i++) begin
            @(posedge clock);
            #1;
            nVec++;
            if (bus.done !== 1'b1) begin
               nMis++;
               $display("FAIL done-hold cycle %0d: got done=%b, want 1", i, bus.done);
            end
         end
         bus.start = 1'b0;
      end
      @(posedge clock);
      #1;
      nVec++;
      if (bus.done !== 1'b0) begin
         nMis++;
         $display("FAIL done-release a=%h b=%h: got done=%b, want 0", a, b, bus.done);
      end
   endtask

   task automatic checkIdle(input string tag);
      logic [23:0] got;
      got = {bus.fpuOut, bus.condCodes, bus.opStatusFlags};
      nVec++;
      if (got !== 24'h0 || bus.done !== 1'b0) begin
         nMis++;
         $display("FAIL %s: got out/cc/flags=%h done=%b, want 000000 done=0", tag, got, bus.done);
      end
   endtask

   // Monitor: one scoreboard pop per rising done.
   logic        doneLast = 1'b0;
   logic [55:0] item;
   logic [23:0] got;
   always @(negedge clock) begin
      if (bus.done === 1'b1 && !doneLast) begin
         got = {bus.fpuOut, bus.condCodes, bus.opStatusFlags};
         nVec++;
         if (expQ.size() == 0) begin
            nMis++;
            $display("FAIL unexpected-result: got %h, want no completion", got);
         end else begin
            item = expQ.pop_front();
            if (got !== item[23:0]) begin
               nMis++;
               $display("FAIL result a=%h b=%h: got out=%h cc=%h fl=%h, want out=%h cc=%h fl=%h",
                        item[55:40], item[39:24], got[23:8], got[7:4], got[3:0],
                        item[23:8], item[7:4], item[3:0]);
            end
         end
      end
      doneLast = (bus.done === 1'b1);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1);
   end

   initial begin
      logic [15:0] a, b;
      reset      = 1'b0;
      bus.start  = 1'b0;
      bus.fpuIn1 = '0;
      bus.fpuIn2 = '0;
      #1 reset = 1'b1;
      #11;
      checkIdle("reset-state");
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < NDIR - 1; i++) begin
         runOp(dirVec[i][55:40], dirVec[i][39:24], dirVec[i][23:0], 1'b0);
      end

      for (int i = 0; i < 200; i++) begin
         a = randOperand();
         b = randOperand();
         runOp(a, b, refMul(a, b), 1'b0);
      end

      // Leave a nonzero result registered, then abort mid-multiply.
      runOp(dirVec[NDIR-1][55:40], dirVec[NDIR-1][39:24], dirVec[NDIR-1][23:0], 1'b0);
      @(negedge clock);
      bus.start  = 1'b1;
      bus.fpuIn1 = 16'h4000;
      bus.fpuIn2 = 16'h4000;
      @(posedge clock);
      #1 bus.start = 1'b0;
      repeat (5) @(posedge clock);
      #2 reset = 1'b1;
      #1;
      checkIdle("reset-abort");
      @(negedge clock);
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      checkIdle("post-abort-idle");

      runOp(16'h4000, 16'h4000, 24'h440000, 1'b0);
      runOp(16'h3E00, 16'h4000, 24'h420000, 1'b1);

      repeat (3) @(posedge clock);
      #1;
      nVec++;
      if (expQ.size() != 0) begin
         nMis++;
         $display("FAIL drain: got %0d pending results, want 0", expQ.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
      $finish;
   end

endmodule
